// File: rtl/regfile_xfer_ctrl_if.sv
// rtl/regfile_xfer_ctrl_if.sv - command handshake and register-file port bundle
interface regfile_xfer_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [AW-1:0]    cmd_src;
    logic [AW-1:0]    cmd_dst;
    logic [WIDTH-1:0] cmd_imm;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [AW-1:0]    rf_read;
    logic [AW-1:0]    rf_write;
    logic [WIDTH-1:0] rf_din;
    logic [WIDTH-1:0] rf_dout;

    // Controller side: accepts commands, drives the register file
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rf_dout,
        output cmd_ready, done, result, rf_read, rf_write, rf_din
    );

    // Initiator / environment side: issues commands, hosts the register file
    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, rf_dout,
        input  cmd_ready, done, result, rf_read, rf_write, rf_din
    );
endinterface

// File: rtl/regfile_xfer_ctrl.sv
// rtl/regfile_xfer_ctrl.sv - register-transfer sequencer for an always-writing 8x8 register file
module regfile_xfer_ctrl #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    regfile_xfer_ctrl_if.slave bus
);
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        SW1  = 3'd2,
        SW2  = 3'd3,
        SW3  = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [1:0]       op_q;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] tmp_q;
    logic [WIDTH-1:0] result_q;
    logic             done_q;
    logic [AW-1:0]    rd_sel;
    logic [AW-1:0]    wr_sel;
    logic [WIDTH-1:0] din_val;
    logic             accept;

    assign accept        = (state == IDLE) && bus.cmd_valid;
    assign bus.cmd_ready = (state == IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.rf_read   = rd_sel;
    assign bus.rf_write  = wr_sel;
    assign bus.rf_din    = din_val;

    // State register; reset aborts any command in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and register-file drive; unless a real write is due, the
    // written register is the one being read and gets its own value back,
    // since the file writes something on every edge.
    always_comb begin
        next_state = state;
        rd_sel     = '0;
        wr_sel     = '0;
        din_val    = bus.rf_dout;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    next_state = (bus.cmd_op == OP_SWAP) ? SW1 : EXEC;
                end
            end
            EXEC: begin
                next_state = IDLE;
                case (op_q)
                    OP_LOAD: begin
                        wr_sel  = dst_q;
                        din_val = imm_q;
                    end
                    OP_MOVE: begin
                        rd_sel = src_q;
                        wr_sel = dst_q;
                    end
                    OP_READ: begin
                        rd_sel = src_q;
                        wr_sel = src_q;
                    end
                    default: begin
                        rd_sel = '0;
                        wr_sel = '0;
                    end
                endcase
            end
            SW1: begin
                next_state = SW2;
                rd_sel     = src_q;
                wr_sel     = src_q;
            end
            SW2: begin
                next_state = SW3;
                rd_sel     = dst_q;
                wr_sel     = src_q;
            end
            SW3: begin
                next_state = IDLE;
                rd_sel     = dst_q;
                wr_sel     = dst_q;
                din_val    = tmp_q;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command capture, swap temporary, READ result and the done pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            tmp_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == EXEC) || (state == SW3);
            if (accept) begin
                op_q  <= bus.cmd_op;
                src_q <= bus.cmd_src;
                dst_q <= bus.cmd_dst;
                imm_q <= bus.cmd_imm;
            end
            if ((state == EXEC) && (op_q == OP_READ)) begin
                result_q <= bus.rf_dout;
            end
            if (state == SW1) begin
                tmp_q <= bus.rf_dout;
            end
        end
    end
endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// tb/tb_regfile_xfer_ctrl.sv - directed scoreboard bench for regfile_xfer_ctrl with a register file
module tb_regfile_xfer_ctrl;
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_SWAP = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    logic [7:0] model [8];
    logic [7:0] exp_q [$];
    logic [7:0] rf_mem [8];

    regfile_xfer_ctrl_if #(.WIDTH(8), .AW(3)) bus ();

    regfile_xfer_ctrl #(.WIDTH(8), .AW(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Register file: no write enable, writes din every edge, combinational read
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) rf_mem[k] <= 8'h00;
        end else begin
            rf_mem[bus.rf_write] <= bus.rf_din;
        end
    end
    assign bus.rf_dout = rf_mem[bus.rf_read];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                         input logic [7:0] imm);
        int         lat;
        int         exp_lat;
        logic [7:0] t;
        logic [7:0] e;
        @(negedge clock);
        chk("ready_idle", bus.cmd_ready, 1);
        bus.cmd_op    = op;
        bus.cmd_src   = src;
        bus.cmd_dst   = dst;
        bus.cmd_imm   = imm;
        bus.cmd_valid = 1'b1;
        case (op)
            OP_LOAD: model[dst] = imm;
            OP_MOVE: model[dst] = model[src];
            OP_SWAP: begin
                t          = model[src];
                model[src] = model[dst];
                model[dst] = t;
            end
            default: exp_q.push_back(model[src]);
        endcase
        exp_lat = (op == OP_SWAP) ? 4 : 2;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 1) begin
                bus.cmd_valid = 1'b0;
                chk("ready_busy", bus.cmd_ready, 0);
            end
        end while (!bus.done && lat < 20);
        chk("done_seen", bus.done, 1);
        chk("latency", lat, exp_lat);
        chk("ready_on_done", bus.cmd_ready, 1);
        if (op == OP_READ) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result", bus.result, e);
            end
        end
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++) issue(OP_READ, 3'(r), 3'd0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_src   = 3'd0;
        bus.cmd_dst   = 3'd0;
        bus.cmd_imm   = 8'h00;
        for (int k = 0; k < 8; k++) model[k] = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_result", bus.result, 0);

        // 1: all registers read zero after reset
        read_all();

        // 2: LOAD one register, the others stay zero
        issue(OP_LOAD, 3'd0, 3'd3, 8'hA5);
        read_all();

        // 3: SWAP
        issue(OP_LOAD, 3'd0, 3'd1, 8'h11);
        issue(OP_LOAD, 3'd0, 3'd6, 8'h66);
        issue(OP_SWAP, 3'd1, 3'd6, 8'h00);
        issue(OP_READ, 3'd1, 3'd0, 8'h00);
        issue(OP_READ, 3'd6, 3'd0, 8'h00);

        // 4: MOVE and SWAP with src==dst
        issue(OP_MOVE, 3'd6, 3'd2, 8'h00);
        issue(OP_SWAP, 3'd2, 3'd2, 8'h00);
        issue(OP_MOVE, 3'd3, 3'd3, 8'h00);
        read_all();

        // 5: back-to-back LOADs with cmd_valid held high
        @(negedge clock);
        bus.cmd_op    = OP_LOAD;
        bus.cmd_dst   = 3'd0;
        bus.cmd_imm   = 8'h10;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            chk("b2b_ready_exec", bus.cmd_ready, 0);
            chk("b2b_no_done", bus.done, 0);
            @(posedge clock);
            #1;
            chk("b2b_done", bus.done, 1);
            chk("b2b_ready_done", bus.cmd_ready, 1);
            model[i] = 8'h10 + 8'(i);
            if (i < 7) begin
                bus.cmd_dst = 3'(i + 1);
                bus.cmd_imm = 8'h10 + 8'(i + 1);
            end else begin
                bus.cmd_valid = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        chk("b2b_done_pulse_end", bus.done, 0);
        read_all();

        // 6: reset during SW2 discards the swap and clears everything
        issue(OP_LOAD, 3'd0, 3'd4, 8'h44);
        issue(OP_LOAD, 3'd0, 3'd5, 8'h55);
        issue(OP_READ, 3'd4, 3'd0, 8'h00);
        @(negedge clock);
        bus.cmd_op    = OP_SWAP;
        bus.cmd_src   = 3'd4;
        bus.cmd_dst   = 3'd5;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("sw2_busy", bus.cmd_ready, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_no_done", bus.done, 0);
        chk("abort_idle", bus.cmd_ready, 1);
        chk("abort_result", bus.result, 0);
        @(posedge clock);
        #1;
        chk("abort_no_done_late", bus.done, 0);
        for (int k = 0; k < 8; k++) model[k] = 8'h00;
        exp_q.delete();
        read_all();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
